// File: rtl/fixed_to_float_if.sv
// Sample stream bus for fixed_to_float: fixed-point samples in, IEEE-754 single out.
interface fixed_to_float_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic [W-1:0] fixed_in;
  logic         out_valid;
  logic [31:0]  result;

  // Producer side: drives samples, observes converted results
  modport master (
    output in_valid,
    output fixed_in,
    input  out_valid,
    input  result
  );

  // Converter side
  modport slave (
    input  in_valid,
    input  fixed_in,
    output out_valid,
    output result
  );
endinterface

// File: rtl/fixed_to_float.sv
// fixed_to_float: 3-stage signed fixed-point (W bits, FRAC_BITS fractional)
// to IEEE-754 single converter, advancing only when clk_en is high.
// Stage 1 sign/magnitude, stage 2 normalise, stage 3 round and pack.
// Build option FIX2FLT_RNE_EN: round-to-nearest-even; otherwise truncate.
module fixed_to_float #(
  parameter int unsigned W         = 32,
  parameter int unsigned FRAC_BITS = 30
) (
  input logic           clk,
  input logic           reset,
  input logic           clk_en,
  fixed_to_float_if.slave bus
);

  localparam int unsigned PW   = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned FW   = ((W - 1) < 25) ? 25 : (W - 1);
  localparam int unsigned EOFF = 127 - FRAC_BITS;

  logic         s1_valid;
  logic         s1_sign;
  logic [W-1:0] s1_mag;

  logic          s2_valid;
  logic          s2_sign;
  logic          s2_zero;
  logic [PW-1:0] s2_p;
  logic [W-1:0]  s2_norm;

  logic        out_valid_q;
  logic [31:0] result_q;

  logic [PW-1:0] p_c;
  logic [W-1:0]  norm_c;
  logic [FW-1:0] ext_c;
  logic [22:0]   frac_c;
  logic [22:0]   frac_rnd_c;
  logic [7:0]    exp_c;
  logic [7:0]    exp_rnd_c;
  logic          unused_c;

  // Stage 1: split sign and take magnitude; -2^(W-1) maps to 2^(W-1) exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
    end else if (clk_en) begin
      s1_valid <= bus.in_valid;
      s1_sign  <= bus.fixed_in[W-1];
      s1_mag   <= bus.fixed_in[W-1] ? (~bus.fixed_in + W'(1)) : bus.fixed_in;
    end
  end

  // Leading-one priority encoder and barrel shift to put the leading one on top
  always_comb begin
    p_c = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (s1_mag[i]) p_c = PW'(i);
    end
    norm_c = s1_mag << (PW'(W - 1) - p_c);
  end

  // Stage 2: register normalised magnitude, leading-one index and zero flag
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b1;
      s2_p     <= '0;
      s2_norm  <= '0;
    end else if (clk_en) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= (s1_mag == '0);
      s2_p     <= p_c;
      s2_norm  <= norm_c;
    end
  end

  // Fraction extraction below the hidden one, zero-padded when narrower than 25 bits
  always_comb begin
    ext_c  = FW'(s2_norm[W-2:0]) << (FW - (W - 1));
    frac_c = ext_c[FW-1 -: 23];
    exp_c  = 8'(EOFF) + 8'(s2_p);
  end

`ifdef FIX2FLT_RNE_EN
  logic        guard_c;
  logic        sticky_c;
  logic        round_up_c;
  logic [23:0] frac_sum_c;

  // Round to nearest even; a carry out of the fraction bumps the exponent
  always_comb begin
    guard_c    = ext_c[FW-24];
    sticky_c   = |ext_c[FW-25:0];
    round_up_c = guard_c & (sticky_c | frac_c[0]);
    frac_sum_c = 24'(frac_c) + 24'(round_up_c);
    frac_rnd_c = frac_sum_c[22:0];
    exp_rnd_c  = exp_c + 8'(frac_sum_c[23]);
    unused_c   = s2_norm[W-1];
  end
`else
  // Truncation toward zero: bits below the fraction are dropped
  always_comb begin
    frac_rnd_c = frac_c;
    exp_rnd_c  = exp_c;
    unused_c   = ^{s2_norm[W-1], ext_c[FW-24:0]};
  end
`endif

  // Stage 3: pack the float; result holds its last valid value when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= 32'h0000_0000;
    end else if (clk_en) begin
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        result_q <= s2_zero ? 32'h0000_0000 : {s2_sign, exp_rnd_c, frac_rnd_c};
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule

// File: doc/fixed_to_float.md
Name: fixed_to_float

Overview:
- Pipelined converter from signed two's-complement fixed point to IEEE-754 single precision.
- Sits directly downstream of the CORDIC core. It turns the core's internal Q2.30 cos/sin result into the 32-bit float presented on the cosine block's result port.
- 3-stage pipeline, one sample per enabled cycle, gated by the shared clk_en.

Parameters:
- W, 32, total width of fixed-point input, including sign bit; legal range 2..64.
- FRAC_BITS, 30, number of fractional bits (default Q2.30); legal range 0..W-1.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- clk_en  input  1  pipeline advance enable; when low, all registers hold
- in_valid  input  1  fixed_in carries a sample this cycle
- fixed_in  input  W  signed fixed-point value, value = fixed_in * 2^-FRAC_BITS
- out_valid  output  1  result carries a converted sample
- result  output  32  IEEE-754 single (sign, 8-bit exponent, 23-bit fraction)

Behaviour:
- Reset: synchronous, active high. At the next rising edge with reset=1, all stage valid flags are cleared, out_valid=0 and result=32'h00000000, regardless of clk_en. Reset mid-stream discards every in-flight sample.
- Advance: registers update only when clk_en=1 and reset=0. With clk_en=0, all data and valid registers hold, outputs stay stable.
- Latency: 3 enabled cycles. A sample accepted on enabled edge N appears with out_valid=1 after enabled edge N+2, i.e. three enabled edges inclusive.
- Throughput: 1 sample per enabled cycle. There is no backpressure.
- Stage valids: in_valid propagates unchanged through the pipeline. Data registers with valid=0 may update but must not affect outputs.
- out_valid=0 output: result holds the value of the last valid sample.
- Stage 1 (sign/magnitude):
  - sign = fixed_in[W-1].
  - mag = |fixed_in|, held in W bits unsigned.
  - The most-negative input (-2^(W-1)) gives mag = 2^(W-1), which is exact with no overflow.
- Stage 2 (normalise):
  - p = index of the most-significant 1 in mag (0..W-1).
  - zero flag = (mag==0).
  - Left-shift mag so bit p lands at the top of a W-bit register. This is a priority encoder plus barrel shifter, single cycle.
- Stage 3 (round/pack):
  - Biased exponent E = 127 + p - FRAC_BITS.
  - Fraction = 23 bits below the leading 1. Guard = next bit; sticky = OR of all remaining lower bits.
  - If W-1 < 24, pad the fraction with zeros; the result is exact.
  - Rounding per the optional feature. A rounding carry out of the fraction clears the fraction and gives E+1.
- Zero: mag==0 gives result = 32'h00000000 (+0.0). A negative zero is never produced.
- Parameter legality: for all legal W/FRAC_BITS, E stays within 1..254, so no denormals or infinities arise. Defaults give E range 97..128.

Optional Feature:
- Macro: FIX2FLT_RNE_EN.
- Defined: round-to-nearest-even on guard/sticky/LSB (round up if guard & (sticky | lsb)).
- Undefined: truncation toward zero; guard and sticky are ignored and no rounding adder is generated.
- Latency is 3 cycles in both builds.

Test Plan:
- Known values, clk_en=1, W=32, FRAC_BITS=30:
  - 32'h40000000 (1.0) -> 32'h3F800000
  - 32'hC0000000 (-1.0) -> 32'hBF800000
  - 32'h20000000 (0.5) -> 32'h3F000000
  - Each appears with out_valid=1 exactly 3 edges after acceptance.
- Extremes:
  - 32'h00000001 (2^-30) -> 32'h30800000
  - 32'h00000000 -> 32'h00000000
  - 32'h80000000 (-2.0) -> 32'hC0000000
- Rounding, input 32'h7FFFFFFF:
  - FIX2FLT_RNE_EN defined -> 32'h40000000 (carry into exponent).
  - FIX2FLT_RNE_EN undefined -> 32'h3FFFFFFF.
- Stall: stream 1.0, 0.5, -1.0 on consecutive cycles, drop clk_en for 4 cycles after the 2nd sample.
  - Outputs freeze during the stall.
  - Order is preserved: 3F800000, 3F000000, BF800000.
  - Each sample has out_valid for exactly one enabled cycle.
- Reset mid-stream: load 2 valid samples, assert reset for 1 cycle with clk_en=0.
  - Next edge: out_valid=0, result=0.
  - No stale sample emerges afterwards.
- Back-to-back in_valid toggling 1,0,1: out_valid pattern is 1,0,1 delayed 3 enabled cycles, and result holds during the 0 slot.
